// File: rtl/req_ack_responder_pkg.sv
// Shared types and sizing helpers for the req/ack responder.
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // Counter must hold LATENCY-1; guard keeps the width legal even for a bad LATENCY.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/req_ack_responder_counter.sv
// Loadable down-counter with a zero flag; paces the PROC phase of the responder.
module resp_delay_counter
    import req_ack_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/req_ack_responder.sv
// Responder end of a req/ack handshake: captures data, waits LATENCY cycles,
// then offers data+OFFSET on a valid/ready response channel.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DW      = 8,
    parameter int LATENCY = 2,
    parameter int OFFSET  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [DW-1:0] req_data,
    output logic          ack,
    output logic          busy,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          rsp_ready
);

    localparam int            CW       = cnt_width(LATENCY);
    localparam logic [CW-1:0] LOAD_VAL = CW'((LATENCY < 1) ? 0 : LATENCY - 1);
    localparam logic [DW-1:0] OFF_V    = DW'(OFFSET);

    if (LATENCY < 1) begin : g_bad_latency
        $error("req_ack_responder: LATENCY must be >= 1");
    end

    resp_state_e   state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          cnt_load, cnt_en, cnt_zero;

    resp_delay_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        ack       = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        unique case (state_q)
            IDLE: begin
                ack = req;
                if (req) begin
                    data_d   = req_data;
                    cnt_load = 1'b1;
                    state_d  = PROC;
                end
            end
            PROC: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    data_d  = data_q + OFF_V;   // carry intentionally dropped
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                // A waiting req is only seen once back in IDLE, never in this cycle.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder (default build and an OFFSET=3 build).
module tb_req_ack_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, rsp_ready;
    logic [7:0] req_data;
    logic       ack, busy, rsp_valid;
    logic [7:0] rsp_data;

    logic       req3, rsp_ready3;
    logic [7:0] req_data3;
    logic       ack3, busy3, rsp_valid3;
    logic [7:0] rsp_data3;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    req_ack_responder #(.DW(8), .LATENCY(2), .OFFSET(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    req_ack_responder #(.DW(8), .LATENCY(2), .OFFSET(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .ack(ack3), .busy(busy3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_ack, input logic e_busy,
                           input logic e_valid, input logic [7:0] e_data);
        chk({tag, ".ack"},       32'(ack),       32'(e_ack));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e_valid));
        chk({tag, ".rsp_data"},  32'(rsp_data),  32'(e_data));
    endtask

    // Handshake contract checked every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("never_ack_busy", 32'(ack && busy), 0);
        chk("never_ack_noreq", 32'(ack && !req), 0);
        chk("req_idle_implies_ack", 32'(!(req && !busy) || ack), 1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; req_data = 8'h00; rsp_ready = 1'b0;
        req3 = 1'b0; req_data3 = 8'h00; rsp_ready3 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk_out("idle", 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // Basic transaction: 0x10 -> 0x11 at T+3
        tick(); req = 1'b1; req_data = 8'h10; rsp_ready = 1'b1; #1;
        chk_out("basic.T", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); req = 1'b0; #1;
        chk_out("basic.T1", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        chk_out("basic.T2", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        chk_out("basic.T3", 1'b0, 1'b1, 1'b1, 8'h11);
        tick(); #1;
        chk_out("basic.T4", 1'b0, 1'b0, 1'b0, 8'h00);

        // Response held while consumer stalls; req high is ignored
        tick(); req = 1'b1; req_data = 8'h10; rsp_ready = 1'b0; #1;
        chk_out("hold.T", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); #1;
        chk_out("hold.T1", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk_out("hold.resp", 1'b0, 1'b1, 1'b1, 8'h11);
        end
        tick(); req = 1'b0; rsp_ready = 1'b1; #1;
        chk_out("hold.release", 1'b0, 1'b1, 1'b1, 8'h11);
        tick(); #1;
        chk_out("hold.done", 1'b0, 1'b0, 1'b0, 8'h00);

        // Wrap: 0xFF+1 -> 0x00, and 0xFE+3 -> 0x01
        tick();
        req = 1'b1; req_data = 8'hFF; rsp_ready = 1'b0;
        req3 = 1'b1; req_data3 = 8'hFE; rsp_ready3 = 1'b0; #1;
        chk("wrap.ack", 32'(ack), 1);
        chk("wrap3.ack", 32'(ack3), 1);
        tick(); req = 1'b0; req3 = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk_out("wrap.T3", 1'b0, 1'b1, 1'b1, 8'h00);
        chk("wrap3.rsp_valid", 32'(rsp_valid3), 1);
        chk("wrap3.rsp_data", 32'(rsp_data3), 32'h01);
        rsp_ready = 1'b1; rsp_ready3 = 1'b1;
        tick(); #1;
        chk("wrap3.idle", 32'(busy3), 0);
        chk_out("wrap.done", 1'b0, 1'b0, 1'b0, 8'h00);

        // Back-to-back with req held high: acks at T and T+4
        tick(); req = 1'b1; req_data = 8'h20; rsp_ready = 1'b1; #1;
        chk_out("b2b.T", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); #1;
        chk_out("b2b.T1", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        chk_out("b2b.T2", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        chk_out("b2b.T3", 1'b0, 1'b1, 1'b1, 8'h21);
        tick(); req_data = 8'h30; #1;
        chk_out("b2b.T4", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); req = 1'b0; #1;
        chk_out("b2b.T5", 1'b0, 1'b1, 1'b0, 8'h00);
        tick(); #1;
        tick(); #1;
        chk_out("b2b.T7", 1'b0, 1'b1, 1'b1, 8'h31);
        tick(); #1;
        chk_out("b2b.done", 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset during PROC abandons the transaction
        tick(); req = 1'b1; req_data = 8'h40; rsp_ready = 1'b0; #1;
        chk_out("rst.T", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); req = 1'b0; rst = 1'b1; #1;
        chk("rst.T1.busy", 32'(busy), 1);
        tick(); rst = 1'b0; rsp_ready = 1'b1; #1;
        chk_out("rst.T2", 1'b0, 1'b0, 1'b0, 8'h00);
        tick(); #1;
        chk_out("rst.T3", 1'b0, 1'b0, 1'b0, 8'h00);
        tick(); req = 1'b1; req_data = 8'h50; #1;
        chk_out("rst.newreq", 1'b1, 1'b0, 1'b0, 8'h00);
        tick(); req = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk_out("rst.newrsp", 1'b0, 1'b1, 1'b1, 8'h51);
        tick(); #1;
        chk_out("rst.done", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
